// File: rtl/cpu_pkg.sv
// Shared CPU fetch-stage definitions: address width, reset vector and PC FSM states.
package cpu_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } pc_state_t;
endpackage

// File: rtl/pc_target_adder.sv
// Combinational modulo-2^W adder used for the sequential and branch targets.
module pc_target_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/pc_next_unit.sv
// Program counter with next-PC selection; redirects arriving during a stall are held until release.
// Optional macro PC_ALIGN_CHECK_EN forces jump targets word-aligned and reports it on 'misaligned'.
module pc_next_unit #(
    parameter int                       XLEN     = cpu_pkg::XLEN,
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_pc_plus4,
    input  logic [XLEN-1:0] imm_shifted,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect_pending,
    output logic            flush
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic            misaligned
`endif
);
    import cpu_pkg::*;

    pc_state_t       state, state_nx;
    logic [XLEN-1:0] pc_q, pc_nx;
    logic [XLEN-1:0] ptgt_q, ptgt_nx;
    logic            flush_q, flush_nx;
    logic [XLEN-1:0] seq, br_tgt, raw_tgt, tgt;
    logic            req;

    pc_target_adder #(.W(XLEN)) u_seq (
        .a   (pc_q),
        .b   ({{(XLEN-3){1'b0}}, 3'd4}),
        .sum (seq)
    );

    pc_target_adder #(.W(XLEN)) u_br (
        .a   (branch_pc_plus4),
        .b   (imm_shifted),
        .sum (br_tgt)
    );

    assign req     = jump | branch_taken;
    assign raw_tgt = jump ? jump_target : br_tgt;

`ifdef PC_ALIGN_CHECK_EN
    logic tgt_mis, pmis_q, pmis_nx, mis_q, mis_nx;
    // Only jump targets are checked; branch targets are aligned by construction.
    assign tgt_mis = jump & (|jump_target[1:0]);
    assign tgt     = tgt_mis ? {raw_tgt[XLEN-1:2], 2'b00} : raw_tgt;
`else
    assign tgt     = raw_tgt;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        ptgt_nx  = ptgt_q;
        flush_nx = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        pmis_nx  = pmis_q;
        mis_nx   = 1'b0;
`endif
        case (state)
            RUN: begin
                if (!stall) begin
                    if (req) begin
                        pc_nx    = tgt;
                        flush_nx = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                        mis_nx   = tgt_mis;
`endif
                    end else begin
                        pc_nx = seq;
                    end
                end else if (req) begin
                    ptgt_nx  = tgt;
                    state_nx = PENDING;
`ifdef PC_ALIGN_CHECK_EN
                    pmis_nx  = tgt_mis;
`endif
                end
            end
            PENDING: begin
                // First captured redirect wins; requests seen here are dropped.
                if (!stall) begin
                    pc_nx    = ptgt_q;
                    flush_nx = 1'b1;
                    state_nx = RUN;
`ifdef PC_ALIGN_CHECK_EN
                    mis_nx   = pmis_q;
`endif
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            ptgt_q  <= '0;
            flush_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            pmis_q  <= 1'b0;
            mis_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            ptgt_q  <= ptgt_nx;
            flush_q <= flush_nx;
`ifdef PC_ALIGN_CHECK_EN
            pmis_q  <= pmis_nx;
            mis_q   <= mis_nx;
`endif
        end
    end

    assign pc               = pc_q;
    assign pc_plus4         = seq;
    assign redirect_pending = (state == PENDING);
    assign flush            = flush_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misaligned       = mis_q;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed vector table, reset-during-pending sequence, random vs model.
module tb_pc_next_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_pc_plus4, imm_shifted, jump_target;
    logic [31:0] pc, pc_plus4;
    logic        redirect_pending, flush;
    logic        mis_obs;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
    assign mis_obs = misaligned;
`else
    assign mis_obs = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pc_next_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_pc_plus4  (branch_pc_plus4),
        .imm_shifted      (imm_shifted),
        .jump             (jump),
        .jump_target      (jump_target),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .redirect_pending (redirect_pending),
        .flush            (flush)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned       (misaligned)
`endif
    );

    typedef struct {
        bit          stall;
        bit          br;
        logic [31:0] bp4;
        logic [31:0] imm;
        bit          j;
        logic [31:0] jt;
        logic [31:0] epc;
        bit          efl;
        bit          epend;
        bit          emis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, bit b, logic [31:0] bp, logic [31:0] im, bit j,
                                logic [31:0] jt, logic [31:0] epc, bit efl, bit epend, bit emis);
        vec_t v;
        v.stall = s; v.br = b; v.bp4 = bp; v.imm = im; v.j = j; v.jt = jt;
        v.epc = epc; v.efl = efl; v.epend = epend; v.emis = emis;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, logic [31:0] epc, bit efl, bit epend, bit emis);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".pc_plus4"}, pc_plus4, epc + 32'd4);
        chk({tag, ".flush"}, {31'b0, flush}, {31'b0, efl});
        chk({tag, ".pending"}, {31'b0, redirect_pending}, {31'b0, epend});
        if (ALIGN) chk({tag, ".misaligned"}, {31'b0, mis_obs}, {31'b0, emis});
    endtask

    task automatic drive(bit r, bit s, bit b, logic [31:0] bp, logic [31:0] im, bit j, logic [31:0] jt);
        @(negedge clock);
        reset = r; stall = s; branch_taken = b; branch_pc_plus4 = bp;
        imm_shifted = im; jump = j; jump_target = jt;
        @(posedge clock);
        #1;
    endtask

    // Reference model state: architectural PC plus an optional held redirect.
    logic [31:0] m_pc, m_ptgt;
    bit          m_pend, m_pmis, m_fl, m_mis;

    task automatic model_step(bit r, bit s, bit b, logic [31:0] bp, logic [31:0] im, bit j, logic [31:0] jt);
        logic [31:0] t;
        bit          bad;
        t   = j ? jt : bp + im;
        bad = ALIGN && j && (jt % 4 != 0);
        if (bad) t = t - (t % 4);
        m_fl  = 0;
        m_mis = 0;
        if (r) begin
            m_pc = RPC; m_pend = 0; m_ptgt = 0; m_pmis = 0;
        end else if (m_pend) begin
            if (!s) begin
                m_pc = m_ptgt; m_fl = 1; m_mis = m_pmis; m_pend = 0;
            end
        end else if (!s) begin
            if (j || b) begin
                m_pc = t; m_fl = 1; m_mis = bad;
            end else begin
                m_pc = m_pc + 4;
            end
        end else if (j || b) begin
            m_pend = 1; m_ptgt = t; m_pmis = bad;
        end
    endtask

    initial begin
        logic [31:0] odd_pc, odd_next;
        odd_pc   = ALIGN ? 32'h0000_0100 : 32'h0000_0103;
        odd_next = ALIGN ? 32'h0000_0104 : 32'h0000_0107;

        //        stall br bp4           imm           j  jt            epc           fl pend mis
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0004, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0008, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_000C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h0000_0040, 32'h0000_0040, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000_0038, 32'hFFFF_FFF0, 0, 32'h0,         32'h0000_0028, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_002C, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,         32'h0,         1, 32'h0000_0200, 32'h0000_002C, 0, 1, 0));
        tbl.push_back(mk(1, 1, 32'h0000_0300, 32'h0,         0, 32'h0,         32'h0000_002C, 0, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_002C, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0204, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000_0500, 32'h0,         1, 32'h0000_0100, 32'h0000_0100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,         32'h0,         1, 32'h0000_0600, 32'h0000_0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h0000_0700, 32'h0000_0600, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         1, 32'h0000_0103, odd_pc,        1, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         odd_next,      0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,         32'h0,         1, 32'h0000_0802, 32'h0000_0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0000_0000, 0, 0, 0));
        // The last two rows are patched below to start from the right PC.
        tbl[19].epc = odd_next; tbl[19].epend = 1;
        tbl[20].epc = ALIGN ? 32'h0000_0800 : 32'h0000_0802; tbl[20].efl = 1; tbl[20].emis = ALIGN;

        reset = 1; stall = 0; branch_taken = 0; jump = 0;
        branch_pc_plus4 = 0; imm_shifted = 0; jump_target = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        check_all("reset", RPC, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++)
            begin
                drive(0, tbl[i].stall, tbl[i].br, tbl[i].bp4, tbl[i].imm, tbl[i].j, tbl[i].jt);
                check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].efl, tbl[i].epend, tbl[i].emis);
            end

        // Reset while a redirect is pending must discard it.
        drive(0, 1, 0, 0, 0, 1, 32'h0000_0900);
        chk("rstpend.pending", {31'b0, redirect_pending}, 32'd1);
        drive(1, 1, 0, 0, 0, 0, 0);
        check_all("rstpend.reset", RPC, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_all("rstpend.after", RPC + 32'd4, 0, 0, 0);

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            bit          r, s, b, j;
            logic [31:0] bp, im, jt;
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 9) < 2);
            j  = ($urandom_range(0, 9) < 2);
            bp = $urandom & 32'hFFFF_FFFC;
            im = $urandom_range(0, 1) ? ($urandom & 32'h0000_0FFC) : (32'hFFFF_F000 | ($urandom & 32'hFFC));
            jt = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
            drive(r, s, b, bp, im, j, jt);
            model_step(r, s, b, bp, im, j, jt);
            check_all($sformatf("rnd%0d", n), m_pc, m_fl, m_pend, m_mis);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
